// File: rtl/bottling_sequencer.sv
// bottling_sequencer: tablet bottling controller with BCD config, paced drops and conveyor handshake
module bottling_sequencer #(
  parameter int TICK_DIV     = 100000,
  parameter int DROP_TICKS   = 2000,
  parameter int CONV_TIMEOUT = 8000,
  parameter int BOTTLES      = 18,
  parameter int MAX_TABS     = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_valid,
  input  logic [3:0] cfg_high_bcd,
  input  logic [3:0] cfg_low_bcd,
  input  logic       abort,
  input  logic       conv_done,
  output logic       drop_pulse,
  output logic       conv_req,
  output logic [5:0] tabs_in_bottle,
  output logic [5:0] bottle_count,
  output logic [9:0] total_tabs,
  output logic       cfg_err,
  output logic       busy,
  output logic       done,
  output logic       fault
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, FILL, CONVEY, DONE, FAULT} state_t;
  state_t state;
  logic [PW-1:0] pre;
  logic [15:0] tmr;
  logic [6:0] target, cfg_target;
  logic tick, cfg_bad, drop_due, last_drop, timeout;
  always_comb begin
    tick = pre == PW'(TICK_DIV - 1);
    cfg_target = 7'(cfg_high_bcd) * 7'd10 + 7'(cfg_low_bcd);
    cfg_bad = cfg_high_bcd > 4'd9 || cfg_low_bcd > 4'd9 || cfg_target == 7'd0 || cfg_target > 7'(MAX_TABS);
    drop_due = tick && tmr == 16'(DROP_TICKS - 1);
    last_drop = {1'b0, tabs_in_bottle} + 7'd1 == target;
    timeout = tick && tmr == 16'(CONV_TIMEOUT - 1);
  end
  assign busy = state == FILL || state == CONVEY;
  assign done = state == DONE;
  assign fault = state == FAULT;
  always_ff @(posedge clk or posedge reset)
    if (reset) pre <= '0;
    else pre <= tick ? '0 : pre + PW'(1);
  // One timer serves both the drop interval in FILL and the conveyor timeout in CONVEY
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      tmr <= '0;
      target <= '0;
      drop_pulse <= 1'b0;
      conv_req <= 1'b0;
      tabs_in_bottle <= '0;
      bottle_count <= '0;
      total_tabs <= '0;
      cfg_err <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      if (abort) begin
        state <= IDLE;
        conv_req <= 1'b0;
      end else
        case (state)
          IDLE, DONE:
            if (cfg_valid) begin
              cfg_err <= cfg_bad;
              if (!cfg_bad) begin
                target <= cfg_target;
                tabs_in_bottle <= '0;
                bottle_count <= '0;
                total_tabs <= '0;
                tmr <= '0;
                state <= FILL;
              end
            end
          FILL:
            if (tick) begin
              tmr <= drop_due ? '0 : tmr + 16'd1;
              if (drop_due) begin
                drop_pulse <= 1'b1;
                tabs_in_bottle <= tabs_in_bottle + 6'd1;
                total_tabs <= total_tabs + 10'd1;
                if (last_drop) begin
                  bottle_count <= bottle_count + 6'd1;
                  conv_req <= 1'b1;
                  state <= CONVEY;
                end
              end
            end
          CONVEY:
            if (conv_done) begin
              conv_req <= 1'b0;
              tabs_in_bottle <= '0;
              tmr <= '0;
              state <= bottle_count == 6'(BOTTLES) ? DONE : FILL;
            end else if (tick) begin
              tmr <= tmr + 16'd1;
              if (timeout) begin
                conv_req <= 1'b0;
                state <= FAULT;
              end
            end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_bottling_sequencer.sv
// tb_bottling_sequencer: config vector table plus drop scoreboard for the bottling sequencer
module tb_bottling_sequencer;
  logic clk = 0, reset = 1, cfg_valid = 0, abort = 0, conv_done = 0;
  logic [3:0] cfg_high_bcd = 0, cfg_low_bcd = 0;
  logic drop_pulse, conv_req, cfg_err, busy, done, fault;
  logic [5:0] tabs_in_bottle, bottle_count;
  logic [9:0] total_tabs;
  logic [27:0] outs;
  int checks = 0, errors = 0;
  typedef struct packed { logic [3:0] hi, lo; logic err, busy; } cfg_vec_t;
  typedef struct { int tabs, total, bottles; } drop_exp_t;
  cfg_vec_t vecs[6];
  logic [1:0] cq[$];
  drop_exp_t dq[$];
  always #5 clk = ~clk;
  assign outs = {drop_pulse, conv_req, tabs_in_bottle, bottle_count, total_tabs, cfg_err, busy, done, fault};
  bottling_sequencer #(.TICK_DIV(1), .DROP_TICKS(2), .CONV_TIMEOUT(5), .BOTTLES(3), .MAX_TABS(50)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_high_bcd(cfg_high_bcd),
    .cfg_low_bcd(cfg_low_bcd), .abort(abort), .conv_done(conv_done), .drop_pulse(drop_pulse),
    .conv_req(conv_req), .tabs_in_bottle(tabs_in_bottle), .bottle_count(bottle_count),
    .total_tabs(total_tabs), .cfg_err(cfg_err), .busy(busy), .done(done), .fault(fault));
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_cfg(input logic [3:0] h, input logic [3:0] l);
    cfg_high_bcd = h;
    cfg_low_bcd = l;
    cfg_valid = 1;
    step();
    cfg_valid = 0;
  endtask
  initial begin
    int prev, cw, c, n;
    logic chk_req;
    drop_exp_t e;
    logic [1:0] r;
    vecs[0] = {4'd5, 4'd1, 1'b1, 1'b0};
    vecs[1] = {4'd0, 4'd0, 1'b1, 1'b0};
    vecs[2] = {4'd10, 4'd2, 1'b1, 1'b0};
    vecs[3] = {4'd9, 4'd10, 1'b1, 1'b0};
    vecs[4] = {4'd5, 4'd0, 1'b0, 1'b1};
    vecs[5] = {4'd0, 4'd1, 1'b0, 1'b1};
    step();
    step();
    check("reset_outs", int'(outs), 0);
    reset = 0;
    step();
    foreach (vecs[i]) begin
      cq.push_back({vecs[i].err, vecs[i].busy});
      send_cfg(vecs[i].hi, vecs[i].lo);
      r = cq.pop_front();
      check($sformatf("cfg%0d_err", i), int'(cfg_err), int'(r[1]));
      check($sformatf("cfg%0d_busy", i), int'(busy), int'(r[0]));
      if (!r[0]) begin
        n = 0;
        repeat (3) begin
          if (drop_pulse) n++;
          step();
        end
        check($sformatf("cfg%0d_no_drop", i), n, 0);
      end else begin
        abort = 1;
        step();
        abort = 0;
        check($sformatf("cfg%0d_abort_idle", i), int'(busy), 0);
      end
    end
    for (int b = 1; b <= 3; b++)
      for (int t = 1; t <= 3; t++) begin
        e.tabs = t;
        e.total = (b - 1) * 3 + t;
        e.bottles = t == 3 ? b : b - 1;
        dq.push_back(e);
      end
    send_cfg(4'd0, 4'd3);
    check("batch_busy", int'(busy), 1);
    prev = 0; cw = 0; c = 0; chk_req = 0;
    while (!done && c < 200) begin
      if (chk_req) begin
        check("conv_req_after_fill", int'(conv_req), 1);
        chk_req = 0;
      end
      if (drop_pulse) begin
        if (dq.size() == 0) check("unexpected_drop", 1, 0);
        else begin
          e = dq.pop_front();
          check("drop_tabs", int'(tabs_in_bottle), e.tabs);
          check("drop_total", int'(total_tabs), e.total);
          check("drop_bottles", int'(bottle_count), e.bottles);
          if (e.tabs != 1 || e.total == 1) check("drop_spacing", c - prev, 2);
          prev = c;
          chk_req = e.tabs == 3;
        end
      end
      cw = conv_req ? cw + 1 : 0;
      conv_done = cw == 2;
      if (conv_done) cw = 0;
      step();
      c++;
    end
    conv_done = 0;
    check("batch_done", int'(done), 1);
    check("batch_total", int'(total_tabs), 9);
    check("batch_bottles", int'(bottle_count), 3);
    check("batch_conv_req", int'(conv_req), 0);
    check("batch_tabs", int'(tabs_in_bottle), 0);
    check("batch_queue_empty", dq.size(), 0);
    send_cfg(4'd5, 4'd1);
    check("done_cfg_err", int'(cfg_err), 1);
    check("done_hold", int'(done), 1);
    check("done_total_hold", int'(total_tabs), 9);
    send_cfg(4'd0, 4'd1);
    check("restart_busy", int'(busy), 1);
    check("restart_err", int'(cfg_err), 0);
    check("restart_total", int'(total_tabs), 0);
    for (int k = 0; k < 20 && !conv_req; k++) step();
    check("fault_conv_req_seen", int'(conv_req), 1);
    n = 0;
    while (!fault && n < 20) begin
      step();
      n++;
    end
    check("fault_ticks", n, 5);
    check("fault_conv_req", int'(conv_req), 0);
    check("fault_bottles", int'(bottle_count), 1);
    send_cfg(4'd0, 4'd5);
    check("fault_ignores_cfg", int'(fault), 1);
    check("fault_cfg_err", int'(cfg_err), 0);
    abort = 1;
    step();
    abort = 0;
    check("abort_fault_clear", int'(fault), 0);
    check("abort_idle", int'(busy | done), 0);
    check("abort_total_hold", int'(total_tabs), 1);
    check("abort_bottles_hold", int'(bottle_count), 1);
    send_cfg(4'd0, 4'd5);
    send_cfg(4'd10, 4'd2);
    check("fill_ignores_cfg_err", int'(cfg_err), 0);
    check("fill_ignores_cfg_busy", int'(busy), 1);
    for (int k = 0; k < 10 && !drop_pulse; k++) step();
    check("first_drop_tabs", int'(tabs_in_bottle), 1);
    step();
    abort = 1;
    step();
    abort = 0;
    check("abort_drop_pulse", int'(drop_pulse), 0);
    check("abort_drop_tabs", int'(tabs_in_bottle), 1);
    check("abort_drop_busy", int'(busy), 0);
    n = 0;
    repeat (4) begin
      step();
      if (drop_pulse) n++;
    end
    check("idle_no_drop", n, 0);
    send_cfg(4'd0, 4'd5);
    for (int k = 0; k < 20 && !(drop_pulse && tabs_in_bottle == 6'd2); k++) step();
    check("pre_reset_tabs", int'(tabs_in_bottle), 2);
    #3;
    reset = 1;
    #1;
    check("async_reset_outs", int'(outs), 0);
    n = 0;
    repeat (3) begin
      step();
      if (drop_pulse) n++;
    end
    check("reset_no_drop", n, 0);
    reset = 0;
    step();
    step();
    check("post_reset_outs", int'(outs), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
